// File: rtl/catc_bus_sequencer_if.sv
// Command/bus bundle for catc_bus_sequencer. cmd_par is present only when
// CATC_SEQ_PARITY_EN is defined.
interface catc_bus_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [19:0] cmd_a;
  logic [19:0] cmd_b;
`ifdef CATC_SEQ_PARITY_EN
  logic        cmd_par;
`endif
  logic [19:0] bus_addr;
  logic [19:0] bus_data;
  logic        busy;
  logic        done;
  logic [3:0]  err_cnt;

`ifdef CATC_SEQ_PARITY_EN
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_par,
    input  cmd_ready, bus_addr, bus_data, busy, done, err_cnt
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_par,
    output cmd_ready, bus_addr, bus_data, busy, done, err_cnt
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready, bus_addr, bus_data, busy, done, err_cnt
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready, bus_addr, bus_data, busy, done, err_cnt
  );
`endif
endinterface

// File: rtl/catc_bus_sequencer.sv
// Buffers {op,a,b} commands in a 2-deep FIFO and replays each as a 4-cycle
// register-write sequence on the downstream bus. Optional: CATC_SEQ_PARITY_EN.
module catc_bus_sequencer #(
  parameter logic [19:0] PARK_ADDR = 20'h00004
) (
  input logic              clk,
  input logic              rst,
  catc_bus_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_WA, S_WB, S_WOP, S_EXEC} state_t;

  state_t      r_state;
  logic [42:0] r_fifo [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [22:0] r_work;
  logic [19:0] r_bus_addr;
  logic [19:0] r_bus_data;
  logic        r_done;

  logic        w_ready;
  logic        w_par_ok;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [42:0] w_head;

  assign w_ready  = (r_count != 2'd2);
  assign w_accept = bus.cmd_valid & w_ready;
  assign w_push   = w_accept & w_par_ok;
  assign w_pop    = (r_count != 2'd0) && ((r_state == S_IDLE) || (r_state == S_EXEC));
  assign w_head   = r_fifo[r_rd_ptr];

`ifdef CATC_SEQ_PARITY_EN
  logic [3:0] r_err_cnt;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Even parity: cmd_par makes the total number of ones over {op,a,b,par} even.
  assign w_par_ok = ((^{bus.cmd_op, bus.cmd_a, bus.cmd_b}) == bus.cmd_par);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err_cnt <= 4'd0;
    else if (w_accept && !w_par_ok)
      r_err_cnt <= sat_inc4(r_err_cnt);
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign w_par_ok    = 1'b1;
  assign bus.err_cnt = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Operand a goes straight onto the bus at pop; only {op,b} are kept for later cycles.
  always_ff @(posedge clk) begin
    if (w_pop)
      r_work <= {w_head[42:40], w_head[19:0]};
  end

  // Outputs are registered from the next state, so the bus always shows the
  // current state's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bus_addr <= PARK_ADDR;
      r_bus_data <= 20'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_EXEC);
      case (r_state)
        S_IDLE, S_EXEC: begin
          if (w_pop) begin
            r_state    <= S_WA;
            r_bus_addr <= 20'd1;
            r_bus_data <= w_head[39:20];
          end else begin
            r_state    <= S_IDLE;
            r_bus_addr <= PARK_ADDR;
            r_bus_data <= 20'd0;
          end
        end
        S_WA: begin
          r_state    <= S_WB;
          r_bus_addr <= 20'd2;
          r_bus_data <= r_work[19:0];
        end
        S_WB: begin
          r_state    <= S_WOP;
          r_bus_addr <= 20'd0;
          r_bus_data <= {17'd0, r_work[22:20]};
        end
        S_WOP: begin
          r_state    <= S_EXEC;
          r_bus_addr <= 20'd0;
          r_bus_data <= {17'd0, r_work[22:20]};
        end
        default: begin
          r_state    <= S_IDLE;
          r_bus_addr <= PARK_ADDR;
          r_bus_data <= 20'd0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_data  = r_bus_data;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state != S_IDLE) || (r_count != 2'd0);

endmodule
